// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch sequencing controller for the CPU front end.
// Owns the program counter. Drives the instruction ROM chip enable and
// address, and waits out multi-cycle ROM accesses. Honours back-pressure
// from ID and takes branch/exception redirects without presenting any
// wrong-path instruction.
//
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   stall             ID cannot accept the current output instruction
//   brEn, brAddr      branch/jump redirect pulse and its target
//   excEn             exception redirect pulse (target EXC_VECTOR)
//   romReady, romInst ROM handshake level and read data
//   pc, romCe         ROM address and chip enable
//   instValid, inst, instPc  registered instruction to ID and its address
module pc_ctrl #(
  parameter int                   PC_LENGTH  = 32,
  parameter int                   PC_STEP    = 4,
  parameter logic [PC_LENGTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]          EXC_VECTOR = 32'h0000_0180
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 brEn,
  input  logic [PC_LENGTH-1:0] brAddr,
  input  logic                 excEn,
  input  logic                 romReady,
  input  logic [31:0]          romInst,
  output logic [PC_LENGTH-1:0] pc,
  output logic                 romCe,
  output logic                 instValid,
  output logic [31:0]          inst,
  output logic [PC_LENGTH-1:0] instPc
);

  localparam logic [PC_LENGTH-1:0] EXC_PC = PC_LENGTH'(EXC_VECTOR);
  localparam logic [PC_LENGTH-1:0] STEP   = PC_LENGTH'(PC_STEP);

  // KILL: a redirect arrived while an access was outstanding; that access
  // must complete (ROM protocol) before the pending target can be issued.
  typedef enum logic [1:0] {IDLE, FETCH, KILL} state_t;

  state_t               state, nstate;
  logic [PC_LENGTH-1:0] pend;
  logic                 redir;
  logic [PC_LENGTH-1:0] tgt;
  logic                 free;

  assign redir = brEn | excEn;
  assign tgt   = excEn ? EXC_PC : brAddr;   // exception has priority
  assign free  = !instValid || !stall;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  // next state
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = FETCH;
      FETCH:   if (redir && !romReady) nstate = KILL;
      KILL:    if (romReady) nstate = FETCH;
      default: nstate = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    romCe = (state != IDLE);
  end

  // pc / pending target / output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      pend      <= '0;
      instValid <= 1'b0;
      inst      <= '0;
      instPc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          instValid <= 1'b0;
          if (redir) pc <= tgt;
        end
        FETCH: begin
          if (redir) begin
            instValid <= 1'b0;
            if (romReady) pc   <= tgt;   // current data is wrong-path, drop it
            else          pend <= tgt;
          end else if (romReady && free) begin
            inst      <= romInst;
            instPc    <= pc;
            instValid <= 1'b1;
            pc        <= pc + STEP;
          end else if (instValid && !stall) begin
            // consumed while the ROM is still busy: bubble
            instValid <= 1'b0;
          end
        end
        KILL: begin
          instValid <= 1'b0;
          if (redir) pend <= tgt;
          // a redirect landing on the completion edge is the newest target
          if (romReady) pc <= redir ? tgt : pend;
        end
        default: instValid <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch sequencing controller for the MIPS CPU front end. It owns the program counter, drives the instruction ROM chip enable and address, and tolerates multi-cycle ROM wait states. It also handles back-pressure (stall) from the ID stage and redirects from branch/jump and exception logic. It presents one registered instruction, with its PC, to ID per accepted fetch.

## Interface
Parameters:
- `PC_LENGTH`, default 32: width of all PC/address signals.
- `PC_STEP`, default 4: sequential PC increment.
- `RESET_PC`, default 0: first fetch address after reset.
- `EXC_VECTOR`, default 32'h0000_0180: exception redirect target, truncated to `PC_LENGTH`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  ID cannot accept the current output instruction.
- `brEn`  in  1  branch/jump redirect, single-cycle pulse.
- `brAddr`  in  `PC_LENGTH`  redirect target, valid with `brEn`.
- `excEn`  in  1  exception redirect to `EXC_VECTOR`, single-cycle pulse.
- `romReady`  in  1  ROM data valid for the current address (level signal, see Operation).
- `romInst`  in  32  ROM read data.
- `pc`  out  `PC_LENGTH`  ROM address.
- `romCe`  out  1  ROM chip enable.
- `instValid`  out  1  `inst`/`instPc` hold a live instruction.
- `inst`  out  32  registered instruction to ID.
- `instPc`  out  `PC_LENGTH`  address `inst` was fetched from.

## Operation
Reset (`rst`=0, immediate, any state):
- State goes to IDLE.
- `pc`=`RESET_PC`, `romCe`=0, `instValid`=0, `inst`=0, `instPc`=0, pending target register=0.

ROM protocol:
- While `romCe`=1 and `romReady`=0, `pc` and `romCe` must not change.
- Once the ROM raises `romReady`, it holds `romReady`=1 and a valid `romInst` until `pc` or `romCe` changes.

Output register:
- Consumed on any edge with `instValid`=1 and `stall`=0.
- It is "free" when `instValid`=0 or it is consumed this cycle.

State machine (IDLE, FETCH, KILL):
- IDLE: `romCe`=0. Next edge goes to FETCH and sets `romCe`=1; `pc` is unchanged.
- FETCH, no redirect this cycle:
  - If `romReady`=1 and the output register is free: `inst`←`romInst`, `instPc`←`pc`, `instValid`←1, `pc`←`pc`+`PC_STEP`. Stay in FETCH.
  - If `romReady`=1 and the output register is not free: hold everything. No capture, `pc` held, `romCe` held at 1.
  - If `romReady`=0: hold `pc`. If the output register is consumed, `instValid`←0.
- FETCH, redirect this cycle (`excEn` or `brEn`):
  - Target is `EXC_VECTOR` if `excEn`, else `brAddr`. `excEn` wins when both are high.
  - `instValid`←0, regardless of `stall`.
  - If `romReady`=1: discard `romInst`, `pc`←target, stay in FETCH.
  - If `romReady`=0: target goes into the pending register and state goes to KILL; `pc` is held.
- KILL: `romCe`=1, `pc` held, `instValid`=0, nothing captured.
  - A new redirect overwrites the pending register (same priority rule).
  - On `romReady`=1: discard data, `pc`←pending target, go to FETCH.
- IDLE with a redirect: `pc`←target, go to FETCH.

Arithmetic and width rules:
- `pc`+`PC_STEP` wraps modulo 2^`PC_LENGTH`.
- `brAddr` is used unmodified; there is no alignment check.

## Timing
- Reset release to first ROM access: `romCe`=1 after the 1st edge, with `pc`=`RESET_PC`.
- Zero-wait ROM (`romReady`=1 whenever `romCe`=1):
  - First `instValid`=1 after the 2nd edge.
  - Then one instruction per cycle while `stall`=0.
- Fetch latency: `romReady` high in cycle N with the output register free gives `instValid`/`inst` after edge N (visible in cycle N+1).
- Redirect latency:
  - Redirect in cycle N with no access outstanding: `pc`=target in cycle N+1, and the first target instruction is valid in N+2 at the earliest.
  - With an outstanding access, the target is issued in the cycle after the ROM completes the killed access.
- Wrong-path guarantee: `instValid`=0 in the cycle after any redirect. No wrong-path instruction is ever presented.
- `stall` with no live instruction (`instValid`=0) has no effect.

## Test plan
- Reset/zero-wait stream: `RESET_PC`=0, `romReady` tied to `romCe`, ROM returns data equal to its address. Required: `instValid`=1 from cycle 2, `instPc` sequence 0,4,8,… with `inst`=`instPc`; after async `rst` low mid-stream, all outputs are 0 and `romCe`=0 within the same cycle.
- Wait states: ROM asserts `romReady` 3 cycles after each address change. Required: `pc` stable during the wait; one instruction per 4 cycles; `instPc`=0,4,8.
- Stall: `stall`=1 for 5 cycles while `instValid`=1 at `instPc`=8. Required: `inst`/`instPc` are frozen and `pc` holds at 12 with `romCe`=1. On release, 8 is consumed, then 12 appears next cycle, with no loss or duplication.
- Branch during outstanding access: `brEn`, `brAddr`=0x40 while a 3-wait access to 0x10 is pending. Required: state KILL; `pc` stays 0x10 until `romReady`, then becomes 0x40. 0x10 data never appears; next `instPc`=0x40.
- Simultaneous `excEn` and `brEn` (`brAddr`=0x80) with a zero-wait ROM. Required: `pc`=0x180 the next cycle and `instValid`=0 for that cycle.
- Wrap: `brAddr`=0xFFFF_FFFC with a zero-wait ROM. Required: after the redirect, `instPc`=0xFFFF_FFFC is followed by `instPc`=0x0000_0000.
